// File: rtl/sar_search_if.sv
// sar_search_if: host/comparator bundle for the successive-approximation
// search controller.
//   start        host -> controller, begin a search (sampled in IDLE only)
//   cmp_less     comparator -> controller, trial < target
//   cmp_equal    comparator -> controller, trial == target
//   cmp_greater  comparator -> controller, trial > target
//   trial        controller -> comparator, registered trial word
//   busy         controller status, high while testing bits
//   done         one-cycle pulse when a search finishes
//   result       found value, held until the next accepted start
//   steps        compare cycles used, held until the next accepted start
//   err          flags were not one-hot during the search, held
// The master side is the host plus comparator; the slave side is sar_search.
interface sar_search_if #(
  parameter int WIDTH = 8
);
  localparam int SW = $clog2(WIDTH + 1);

  logic             start;
  logic             cmp_less;
  logic             cmp_equal;
  logic             cmp_greater;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [SW-1:0]    steps;
  logic             err;

  modport master (
    output start, cmp_less, cmp_equal, cmp_greater,
    input  trial, busy, done, result, steps, err
  );

  modport slave (
    input  start, cmp_less, cmp_equal, cmp_greater,
    output trial, busy, done, result, steps, err
  );
endinterface

// File: rtl/sar_search.sv
// sar_search: successive-approximation search controller. Presents a trial
// word to an external magnitude comparator and binary-searches the hidden
// target MSB-first, one bit per cycle, exiting early on equality.
// Ports:
//   clk  single clock, all state on the rising edge
//   rst  asynchronous, active-high reset (aborts a search with no done)
//   bus  sar_search_if slave modport (start, comparator flags in;
//        trial, busy, done, result, steps, err out)
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  sar_search_if.slave bus
);

  localparam int SW = $clog2(WIDTH + 1);
  // bit_idx needs at least one bit even for a degenerate 1-bit search
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;      // bits confirmed so far
  logic [IW-1:0]    bit_idx;  // bit currently under test

  logic             flags_ok;
  logic [WIDTH-1:0] new_acc;
  logic [IW-1:0]    idx_dec;
  logic [WIDTH-1:0] next_trial;

  // Decision for the current trial: keep the bit when trial is still below
  // the target, then probe the next lower bit on top of the kept bits.
  always_comb begin
    flags_ok = 1'b0;
    case ({bus.cmp_less, bus.cmp_equal, bus.cmp_greater})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
    new_acc    = bus.cmp_less ? bus.trial : acc;
    idx_dec    = bit_idx - IW'(1);
    next_trial = new_acc | (WIDTH'(1) << idx_dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      bit_idx    <= IW'(WIDTH - 1);
      bus.trial  <= '0;
      bus.result <= '0;
      bus.steps  <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.trial <= WIDTH'(1) << (WIDTH - 1);
            acc       <= '0;
            bit_idx   <= IW'(WIDTH - 1);
            bus.steps <= '0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= TEST;
          end
        end

        TEST: begin
          bus.steps <= bus.steps + SW'(1);
          if (!flags_ok) begin
            bus.err    <= 1'b1;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else if (bus.cmp_equal) begin
            bus.result <= bus.trial;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            acc <= new_acc;
            if (bit_idx == '0) begin
              // Last bit resolved without an exact hit (e.g. target 0)
              bus.result <= new_acc;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              state      <= DONE;
            end else begin
              bit_idx   <= idx_dec;
              bus.trial <= next_trial;
            end
          end
        end

        DONE: begin
          // trial keeps its last value; start here is deliberately not seen
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed bench for sar_search (WIDTH=8). A behavioural
// comparator drives the flags combinationally from trial and a target value;
// expected results, step counts and trial sequences are hand-computed.
module tb_sar_search;

  logic       clk;
  logic       rst;
  logic [7:0] target;
  logic       force_bad;
  int         checks;
  int         errors;
  logic [7:0] tq[$];
  int         cyc;
  int         seen_done;

  sar_search_if #(.WIDTH(8)) bus ();

  sar_search #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (force_bad) begin
      bus.cmp_less    = 1'b1;
      bus.cmp_equal   = 1'b0;
      bus.cmp_greater = 1'b1;
    end else begin
      bus.cmp_less    = (bus.trial < target);
      bus.cmp_equal   = (bus.trial == target);
      bus.cmp_greater = (bus.trial > target);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge. Pulses start, logs every TEST-cycle trial, and
  // returns with cyc = cycle (counted from the start edge) where done is seen.
  task automatic run(input logic [7:0] tgt, input int bad_cycle, input int extra_start,
                     output int cyc_o);
    int c;
    target = tgt;
    tq.delete();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 1;
    while (!bus.done && c < 20) begin
      if (bus.busy) tq.push_back(bus.trial);
      force_bad = (c == bad_cycle);
      bus.start = (c == extra_start);
      @(posedge clk); #1;
      c++;
    end
    force_bad = 1'b0;
    bus.start = 1'b0;
    chk("done_within_bound", {31'd0, bus.done}, 32'd1);
    cyc_o = c;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    target    = 8'h00;
    force_bad = 1'b0;
    bus.start = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_trial",  {24'd0, bus.trial},  32'h0);
    chk("rst_busy",   {31'd0, bus.busy},   32'h0);
    chk("rst_done",   {31'd0, bus.done},   32'h0);
    chk("rst_result", {24'd0, bus.result}, 32'h0);
    chk("rst_steps",  {28'd0, bus.steps},  32'h0);
    chk("rst_err",    {31'd0, bus.err},    32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1. Immediate hit on the MSB trial
    run(8'h80, 0, 0, cyc);
    chk("t1_latency", cyc,                   32'd2);
    chk("t1_result",  {24'd0, bus.result},   32'h80);
    chk("t1_steps",   {28'd0, bus.steps},    32'd1);
    chk("t1_err",     {31'd0, bus.err},      32'd0);
    chk("t1_busy",    {31'd0, bus.busy},     32'd0);
    chk("t1_ntrials", tq.size(),             32'd1);
    @(posedge clk); #1;
    chk("t1_done_pulse", {31'd0, bus.done},  32'd0);
    chk("t1_result_hold", {24'd0, bus.result}, 32'h80);
    chk("t1_trial_hold",  {24'd0, bus.trial},  32'h80);

    // 2. Mixed keep/drop decisions with early exit
    run(8'h5A, 0, 0, cyc);
    chk("t2_latency", cyc,                 32'd8);
    chk("t2_result",  {24'd0, bus.result}, 32'h5A);
    chk("t2_steps",   {28'd0, bus.steps},  32'd7);
    chk("t2_ntrials", tq.size(),           32'd7);
    if (tq.size() == 7) begin
      chk("t2_trial0", {24'd0, tq[0]}, 32'h80);
      chk("t2_trial1", {24'd0, tq[1]}, 32'h40);
      chk("t2_trial2", {24'd0, tq[2]}, 32'h60);
      chk("t2_trial3", {24'd0, tq[3]}, 32'h50);
      chk("t2_trial4", {24'd0, tq[4]}, 32'h58);
      chk("t2_trial5", {24'd0, tq[5]}, 32'h5C);
      chk("t2_trial6", {24'd0, tq[6]}, 32'h5A);
    end
    @(posedge clk); #1;

    // 3. Target 0: never equal, full-length search returns 0
    run(8'h00, 0, 0, cyc);
    chk("t3_latency", cyc,                 32'd9);
    chk("t3_result",  {24'd0, bus.result}, 32'h00);
    chk("t3_steps",   {28'd0, bus.steps},  32'd8);
    chk("t3_err",     {31'd0, bus.err},    32'd0);
    if (tq.size() == 8) begin
      chk("t3_trial1", {24'd0, tq[1]}, 32'h40);
      chk("t3_trial7", {24'd0, tq[7]}, 32'h01);
    end else begin
      chk("t3_ntrials", tq.size(), 32'd8);
    end
    @(posedge clk); #1;

    // 4. Target 0xFF: equality on the last bit
    run(8'hFF, 0, 0, cyc);
    chk("t4_latency", cyc,                 32'd9);
    chk("t4_result",  {24'd0, bus.result}, 32'hFF);
    chk("t4_steps",   {28'd0, bus.steps},  32'd8);
    if (tq.size() == 8) begin
      chk("t4_trial1", {24'd0, tq[1]}, 32'hC0);
      chk("t4_trial6", {24'd0, tq[6]}, 32'hFE);
    end else begin
      chk("t4_ntrials", tq.size(), 32'd8);
    end
    // start during the DONE cycle is not seen
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("t4_start_in_done_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    chk("t4_start_in_done_idle", {31'd0, bus.busy}, 32'd0);
    chk("t4_result_hold", {24'd0, bus.result}, 32'hFF);

    // 5. Non-one-hot flags in the third TEST cycle
    run(8'h5A, 3, 0, cyc);
    chk("t5_latency", cyc,                 32'd4);
    chk("t5_err",     {31'd0, bus.err},    32'd1);
    chk("t5_result",  {24'd0, bus.result}, 32'h00);
    chk("t5_steps",   {28'd0, bus.steps},  32'd3);
    @(posedge clk); #1;
    chk("t5_err_hold", {31'd0, bus.err},   32'd1);

    // 6a. Establish a nonzero held result, then reset mid-search
    run(8'h37, 0, 0, cyc);
    chk("t6_pre_result", {24'd0, bus.result}, 32'h37);
    @(posedge clk); #1;
    target = 8'h5A;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("t6_trial_before_rst", {24'd0, bus.trial}, 32'h40);
    rst = 1'b1;
    #1;
    chk("t6_rst_trial",  {24'd0, bus.trial},  32'h0);
    chk("t6_rst_busy",   {31'd0, bus.busy},   32'h0);
    chk("t6_rst_result", {24'd0, bus.result}, 32'h0);
    chk("t6_rst_steps",  {28'd0, bus.steps},  32'h0);
    chk("t6_rst_done",   {31'd0, bus.done},   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen_done = 1;
    end
    chk("t6_no_done_after_abort", seen_done, 32'd0);

    // 6b. Restart with a spurious start during busy
    run(8'h5A, 0, 2, cyc);
    chk("t6_restart_latency", cyc,                 32'd8);
    chk("t6_restart_result",  {24'd0, bus.result}, 32'h5A);
    chk("t6_restart_steps",   {28'd0, bus.steps},  32'd7);
    if (tq.size() == 7) begin
      chk("t6_restart_trial2", {24'd0, tq[2]}, 32'h60);
      chk("t6_restart_trial3", {24'd0, tq[3]}, 32'h50);
    end else begin
      chk("t6_restart_ntrials", tq.size(), 32'd7);
    end
    @(posedge clk); #1;
    chk("t6_idle_after", {31'd0, bus.busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
